phy_link_ctrl: RTL and testbench



---
 rtl/phy_pkg.sv | 18 +
 rtl/phy_com_detect.sv | 31 +++
 rtl/phy_link_ctrl.sv | 146 ++++++++++++++
 tb/tb_phy_link_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared types and constants for the PCIe PHY link controller and the receive-side aligner.
package phy_pkg;

    localparam int unsigned LANES   = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STATE_W = 3;

    localparam logic [BYTE_W-1:0] COM_SYM = 8'hBC;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET   = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_ALIGN   = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_RECOVER = 3'd4
    } state_e;

endpackage

// File: rtl/phy_com_detect.sv
// Combinational COM ordered-set and lane-skew detection across the four lanes.
module phy_com_detect
    import phy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM = COM_SYM
) (
    input  logic [BYTE_W-1:0] in0,
    input  logic [BYTE_W-1:0] in1,
    input  logic [BYTE_W-1:0] in2,
    input  logic [BYTE_W-1:0] in3,
    input  logic [LANES-1:0]  validin,
    output logic              all_com_c,
    output logic              skew_c,
    output logic [LANES-1:0]  skew_mask_c
);

    logic [2:0] pop;
    logic       majority;

    assign all_com_c = (validin == 4'hF) && (in0 == COM) && (in1 == COM)
                     && (in2 == COM) && (in3 == COM);

    assign skew_c = (validin != 4'h0) && (validin != 4'hF);

    assign pop = 3'(validin[0]) + 3'(validin[1]) + 3'(validin[2]) + 3'(validin[3]);
    assign majority = (pop >= 3'd2);

    // Lanes that disagree with the majority vote; zero when lanes agree.
    assign skew_mask_c = skew_c ? (validin ^ {LANES{majority}}) : 4'h0;

endmodule

// File: rtl/phy_link_ctrl.sv
// Link-training and lane-sequencing controller for the 4-lane PHY datapath.
// Optional PHY_LINK_STATS_EN adds a saturating retrain counter output.
module phy_link_ctrl
    import phy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM        = COM_SYM,
    parameter int unsigned       ALIGN_CNT  = 4,
    parameter int unsigned       ERR_MAX    = 3,
    parameter int unsigned       RECOVER_TO = 16,
    parameter int unsigned       CNT_W      = 5
) (
    input  logic                clk4f,
    input  logic                reset,
    input  logic [BYTE_W-1:0]   in0,
    input  logic [BYTE_W-1:0]   in1,
    input  logic [BYTE_W-1:0]   in2,
    input  logic [BYTE_W-1:0]   in3,
    input  logic [LANES-1:0]    validin,
    output logic                link_up,
    output logic                recir_sel,
    output logic [LANES-1:0]    valid_gated,
    output logic [STATE_W-1:0]  state,
    output logic [LANES-1:0]    lane_skew
`ifdef PHY_LINK_STATS_EN
    ,
    output logic [15:0]         retrain_cnt
`endif
);

    logic             all_com_c;
    logic             skew_c;
    logic [LANES-1:0] skew_mask_c;

    state_e           st, nxt_st;
    logic [CNT_W-1:0] align_cnt, nxt_align_cnt;
    logic [CNT_W-1:0] err_cnt, nxt_err_cnt;
    logic [CNT_W-1:0] to_cnt, nxt_to_cnt;

    phy_com_detect #(.COM(COM)) u_detect (
        .in0         (in0),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .validin     (validin),
        .all_com_c   (all_com_c),
        .skew_c      (skew_c),
        .skew_mask_c (skew_mask_c)
    );

    // Next-state and counter decode; counters compare against terminal-1 so they never wrap.
    always_comb begin
        nxt_st        = st;
        nxt_align_cnt = align_cnt;
        nxt_err_cnt   = err_cnt;
        nxt_to_cnt    = to_cnt;
        case (st)
            ST_RESET: begin
                nxt_st        = ST_SEARCH;
                nxt_align_cnt = '0;
                nxt_err_cnt   = '0;
                nxt_to_cnt    = '0;
            end
            ST_SEARCH: begin
                if (all_com_c) begin
                    nxt_st        = ST_ALIGN;
                    nxt_align_cnt = CNT_W'(1);
                end
            end
            ST_ALIGN: begin
                if (!all_com_c) begin
                    nxt_st        = ST_SEARCH;
                    nxt_align_cnt = '0;
                end else if (align_cnt == CNT_W'(ALIGN_CNT - 1)) begin
                    nxt_st        = ST_ACTIVE;
                    nxt_align_cnt = '0;
                end else begin
                    nxt_align_cnt = align_cnt + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!skew_c) begin
                    nxt_err_cnt = '0;
                end else if (err_cnt == CNT_W'(ERR_MAX - 1)) begin
                    nxt_st      = ST_RECOVER;
                    nxt_err_cnt = '0;
                end else begin
                    nxt_err_cnt = err_cnt + CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                if (all_com_c) begin
                    nxt_st        = ST_ALIGN;
                    nxt_align_cnt = CNT_W'(1);
                    nxt_to_cnt    = '0;
                end else if (to_cnt == CNT_W'(RECOVER_TO - 1)) begin
                    nxt_st     = ST_SEARCH;
                    nxt_to_cnt = '0;
                end else begin
                    nxt_to_cnt = to_cnt + CNT_W'(1);
                end
            end
            default: begin
                nxt_st        = ST_SEARCH;
                nxt_align_cnt = '0;
                nxt_err_cnt   = '0;
                nxt_to_cnt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk4f) begin
        if (reset) begin
            st          <= ST_RESET;
            align_cnt   <= '0;
            err_cnt     <= '0;
            to_cnt      <= '0;
            link_up     <= 1'b0;
            recir_sel   <= 1'b1;
            valid_gated <= '0;
            lane_skew   <= '0;
        end else begin
            st          <= nxt_st;
            align_cnt   <= nxt_align_cnt;
            err_cnt     <= nxt_err_cnt;
            to_cnt      <= nxt_to_cnt;
            link_up     <= (nxt_st == ST_ACTIVE);
            recir_sel   <= (nxt_st != ST_ACTIVE);
            // Ordered sets are consumed here and never reach the striping stage.
            valid_gated <= ((nxt_st == ST_ACTIVE) && !all_com_c) ? validin : 4'h0;
            lane_skew   <= skew_mask_c;
        end
    end

    assign state = st;

`ifdef PHY_LINK_STATS_EN
    always_ff @(posedge clk4f) begin
        if (reset) begin
            retrain_cnt <= '0;
        end else if ((st == ST_ACTIVE) && (nxt_st == ST_RECOVER) && (retrain_cnt != 16'hFFFF)) begin
            retrain_cnt <= retrain_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed and randomized bench for phy_link_ctrl against a run-length reference model.
module tb_phy_link_ctrl;

    localparam int ALIGN_N   = 4;
    localparam int ERR_N     = 3;
    localparam int RECOVER_N = 16;

    logic       clk4f = 1'b0;
    logic       reset;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] validin;
    logic       link_up;
    logic       recir_sel;
    logic [3:0] valid_gated;
    logic [2:0] state;
    logic [3:0] lane_skew;
`ifdef PHY_LINK_STATS_EN
    logic [15:0] retrain_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: state number plus run lengths of the relevant input patterns.
    int       m_state;
    int       com_run;
    int       skew_run;
    int       idle_run;
    bit       m_link;
    bit [3:0] m_vg;
    bit [3:0] m_ls;
    int       m_retrain;

    phy_link_ctrl dut (
        .clk4f       (clk4f),
        .reset       (reset),
        .in0         (in0),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .validin     (validin),
        .link_up     (link_up),
        .recir_sel   (recir_sel),
        .valid_gated (valid_gated),
        .state       (state),
        .lane_skew   (lane_skew)
`ifdef PHY_LINK_STATS_EN
        ,
        .retrain_cnt (retrain_cnt)
`endif
    );

    always #5 clk4f = ~clk4f;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit [3:0] v, input bit [7:0] b0, input bit [7:0] b1,
                              input bit [7:0] b2, input bit [7:0] b3);
        bit allc, sk, maj;
        int ones, nst;
        if (r) begin
            m_state = 0; com_run = 0; skew_run = 0; idle_run = 0;
            m_link = 0; m_vg = '0; m_ls = '0; m_retrain = 0;
            return;
        end
        allc = (v == 4'hF) && (b0 == 8'hBC) && (b1 == 8'hBC) && (b2 == 8'hBC) && (b3 == 8'hBC);
        ones = $countones(v);
        sk   = (ones != 0) && (ones != 4);
        maj  = (ones >= 2);
        nst  = m_state;
        case (m_state)
            0: nst = 1;
            1: if (allc) begin nst = 2; com_run = 1; end
            2: begin
                if (allc) begin
                    com_run++;
                    if (com_run == ALIGN_N) begin nst = 3; com_run = 0; end
                end else begin
                    nst = 1; com_run = 0;
                end
            end
            3: begin
                if (sk) begin
                    skew_run++;
                    if (skew_run == ERR_N) begin
                        nst = 4; skew_run = 0;
                        if (m_retrain < 65535) m_retrain++;
                    end
                end else begin
                    skew_run = 0;
                end
            end
            4: begin
                if (allc) begin
                    nst = 2; com_run = 1; idle_run = 0;
                end else begin
                    idle_run++;
                    if (idle_run == RECOVER_N) begin nst = 1; idle_run = 0; end
                end
            end
            default: nst = 1;
        endcase
        m_state = nst;
        m_link  = (nst == 3);
        m_vg    = (nst == 3 && !allc) ? v : 4'h0;
        for (int i = 0; i < 4; i++) m_ls[i] = sk && (v[i] != maj);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"},       16'(state),       16'(m_state));
        check({tag, ".link_up"},     16'(link_up),     16'(m_link));
        check({tag, ".recir_sel"},   16'(recir_sel),   16'(!m_link));
        check({tag, ".valid_gated"}, 16'(valid_gated), 16'(m_vg));
        check({tag, ".lane_skew"},   16'(lane_skew),   16'(m_ls));
`ifdef PHY_LINK_STATS_EN
        check({tag, ".retrain_cnt"}, retrain_cnt,      16'(m_retrain));
`endif
    endtask

    // Drive one cycle of inputs away from the edge, step the model, sample #1 after the edge.
    task automatic cycle(input string tag, input bit r, input bit [3:0] v, input bit [7:0] b0,
                         input bit [7:0] b1, input bit [7:0] b2, input bit [7:0] b3);
        reset = r; validin = v; in0 = b0; in1 = b1; in2 = b2; in3 = b3;
        model_step(r, v, b0, b1, b2, b3);
        @(posedge clk4f);
        #1;
        compare_all(tag);
    endtask

    task automatic com_cycle(input string tag);
        cycle(tag, 1'b0, 4'hF, 8'hBC, 8'hBC, 8'hBC, 8'hBC);
    endtask

    initial begin
        bit [3:0] v;
        bit [7:0] b [4];
        int kind;

        reset = 1'b1; validin = '0; in0 = '0; in1 = '0; in2 = '0; in3 = '0;

        // Reset hold, then idle into SEARCH.
        for (int i = 0; i < 3; i++) cycle("reset", 1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        check("reset_state", 16'(state), 16'd0);
        cycle("idle", 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        check("search_entry", 16'(state), 16'd1);

        // Training: four COM cycles bring the link up.
        for (int i = 0; i < ALIGN_N; i++) com_cycle("train");
        check("train_link_up", 16'(link_up), 16'd1);
        check("train_vg_on_com", 16'(valid_gated), 16'd0);

        // Data passes through, a skip ordered set is gated for one cycle only.
        cycle("data0", 1'b0, 4'hF, 8'hFF, 8'hEE, 8'hDD, 8'hCC);
        check("data_vg", 16'(valid_gated), 16'hF);
        com_cycle("skip_os");
        check("skip_vg", 16'(valid_gated), 16'h0);
        check("skip_state", 16'(state), 16'd3);
        cycle("data1", 1'b0, 4'hF, 8'hFF, 8'hEE, 8'hDD, 8'hCC);

        // Lane 3 drops out for three cycles -> RECOVER, then timeout -> SEARCH.
        for (int i = 0; i < ERR_N; i++) cycle("skew", 1'b0, 4'b0111, 8'h11, 8'h22, 8'h33, 8'h44);
        check("skew_mask", 16'(lane_skew), 16'b1000);
        check("skew_recover", 16'(state), 16'd4);
        check("skew_recir", 16'(recir_sel), 16'd1);
        for (int i = 0; i < RECOVER_N; i++) cycle("recover_idle", 1'b0, 4'hF, 8'h55, 8'h55, 8'h55, 8'h55);
        check("recover_timeout", 16'(state), 16'd1);

        // Broken training run falls back to SEARCH, then a fresh run from zero.
        com_cycle("align_a");
        com_cycle("align_b");
        cycle("align_break", 1'b0, 4'hF, 8'hBC, 8'hBC, 8'h77, 8'hBC);
        check("align_break_state", 16'(state), 16'd1);
        for (int i = 0; i < ALIGN_N - 1; i++) com_cycle("retrain");
        check("retrain_not_yet", 16'(state), 16'd2);
        com_cycle("retrain_last");
        check("retrain_active", 16'(state), 16'd3);

        // Second retrain event, then reset mid-ACTIVE.
        for (int i = 0; i < ERR_N; i++) cycle("skew2", 1'b0, 4'b0010, 8'h00, 8'h00, 8'h00, 8'h00);
        check("skew2_mask", 16'(lane_skew), 16'b0010);
`ifdef PHY_LINK_STATS_EN
        check("retrain_cnt_two", retrain_cnt, 16'd2);
`endif
        com_cycle("recover_com");
        for (int i = 0; i < ALIGN_N - 1; i++) com_cycle("realign");
        check("realign_active", 16'(state), 16'd3);
        cycle("mid_reset", 1'b1, 4'hF, 8'h12, 8'h34, 8'h56, 8'h78);
        check("mid_reset_state", 16'(state), 16'd0);
        check("mid_reset_recir", 16'(recir_sel), 16'd1);
        cycle("post_reset", 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);

        // Randomized phase biased toward COM runs and skew bursts.
        for (int n = 0; n < 3000; n++) begin
            kind = int'($urandom_range(0, 9));
            for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
            v = 4'($urandom);
            case (kind)
                0, 1, 2, 3: begin v = 4'hF; for (int i = 0; i < 4; i++) b[i] = 8'hBC; end
                4, 5:       if (v == 4'h0 || v == 4'hF) v = 4'b0101;
                6:          v = 4'h0;
                7:          v = 4'hF;
                8: begin
                    v = 4'hF;
                    for (int i = 0; i < 4; i++) b[i] = 8'hBC;
                    b[$urandom_range(0, 3)] = 8'h7C;
                end
                default: ;
            endcase
            cycle("rand", ($urandom_range(0, 199) == 0), v, b[0], b[1], b[2], b[3]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
